add_round_key_stage: RTL and testbench
======================================

Name: add_round_key_stage

Overview:
- Registered AES-128 AddRoundKey stage that consumes a 4x4 byte state and XORs it with the current round key.
- Inputs per round: plaintext for round 0, mixColumns output for rounds 1-9, shiftRows output for round 10.
- Expands the key schedule on the fly, one round key per accepted beat; no 176-byte key RAM.
- Uses valid/ready handshakes on both sides and sits directly downstream of mixColumns in the round datapath.

Parameters:
- NR, 10: index of the last round. Only 10 (AES-128) is supported; the Rcon sequence covers rounds 1..10.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- key_load  input  1  load key_in as round key 0; aborts any block in progress
- key_in  input  [7:0] [3:0][3:0]  cipher key, key_in[row][col]; column c is word w[c]
- key_ready  output  1  a key has been loaded since reset
- in_valid  input  1  state beat valid
- in_ready  output  1  stage can accept a beat
- in  input  [7:0] [3:0][3:0]  state, in[row][col]
- out_valid  output  1  out register holds a result
- out_ready  input  1  downstream accepts
- out  output  [7:0] [3:0][3:0]  in XOR round key
- out_round  output  4  round index (0..NR) applied to out
- out_last  output  1  out_round == NR

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-low (rst_n).
- Reset values:
  - key_ready=0, out_valid=0, out=0, out_round=0, out_last=0.
  - Internal: round_cnt=0, rk=0, key0=0, rcon=8'h01.
- States: NOKEY (key_ready=0) and KEYED.
  - NOKEY -> KEYED on key_load.
  - KEYED stays KEYED; a further key_load reloads.
- in_ready = key_ready & ~key_load & (~out_valid | out_ready). Beats offered in NOKEY are never accepted.
- key_load cycle:
  - key0<=key_in, rk<=key_in, round_cnt<=0, rcon<=8'h01.
  - No beat is accepted in that cycle.
  - The out register is untouched; a pending result still drains.
- Accept (in_valid & in_ready), latency 1 cycle:
  - out<=in^rk (bytewise, same [row][col]), out_round<=round_cnt, out_last<=(round_cnt==NR), out_valid<=1.
  - If round_cnt==NR: round_cnt<=0, rk<=key0, rcon<=8'h01, so the next block starts with no reload.
  - Else: rk<=expand(rk,rcon), rcon<=xtime(rcon), round_cnt<=round_cnt+1.
- xtime: shift left 1, XOR 8'h1b if bit7 was set. Sequence: 01,02,04,08,10,20,40,80,1b,36.
- expand(rk,rcon), with w[c]=rk[*][c]:
  - t[r] = Sbox(w[3][(r+1)%4]), i.e. RotWord then SubWord.
  - t[0] ^= rcon.
  - n[0]=w[0]^t, n[1]=w[1]^n[0], n[2]=w[2]^n[1], n[3]=w[3]^n[2].
  - Four S-box lookups are combinational inside the block (forward AES S-box).
- Drain: out_valid clears when out_ready & out_valid and no new accept occurs in the same cycle. Simultaneous drain and accept gives back-to-back throughput of 1 beat/cycle.
- Backpressure: while out_valid & ~out_ready, out, out_round and out_last hold stable and in_ready=0.
- Reset mid-block: everything returns to reset values; a new key_load is required.

Test Plan:
- Key load and round 0: reset; key_load key 2b7e151628aed2a6abf7158809cf4f3c (col0 rows=2b,7e,15,16); beat in=all zero -> one cycle later out_valid=1, out equals the key, out_round=0, out_last=0.
- Round-key expansion: 11 zero beats back-to-back with out_ready=1 -> in_ready held 1 throughout.
  - Round 1 out cols = a0fafe17, 88542cb1, 23a33939, 2a6c7605.
  - Round 10 out = d014f9a8c9ee2589e13f0cc8b6630ca6, out_last=1.
- Wrap: 12th zero beat -> out_round=0 and out=2b7e1516... again, with no key_load.
- Backpressure: out_ready=0 for 3 cycles while round 1 is valid -> out stable, in_ready=0; a pending in beat is accepted only in the cycle out_ready rises.
- Abort: key_load at round_cnt=4 with key 000102...0f while a beat is pending -> pending out still drains; next beat gives out_round=0, out=in^000102...0f; round 1 key = d6aa74fdd2af72fadaa678f1d6ab76fe.
- Reset/nokey: assert rst_n=0 mid-block -> all outputs 0 immediately; in_valid=1 before any key_load -> in_ready=0, out_valid stays 0.

Source files
------------

// File: rtl/add_round_key_stage.sv
// Registered AES-128 AddRoundKey stage with on-the-fly key expansion.
// One round key is consumed per accepted beat; the schedule rewinds to key0 after the last round.
module add_round_key_stage #(
    parameter int NR = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 key_load,
    input  logic [3:0][3:0][7:0] key_in,
    output logic                 key_ready,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [3:0][3:0][7:0] in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [3:0][3:0][7:0] out,
    output logic [3:0]           out_round,
    output logic                 out_last
);

    localparam logic [3:0] LAST_ROUND = 4'(NR);

    // Forward AES S-box, element 0 is the leftmost byte.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    typedef enum logic {NOKEY, KEYED} state_t;

    state_t                 state;
    logic [3:0][3:0][7:0]   key0;
    logic [3:0][3:0][7:0]   rk;
    logic [3:0][3:0][7:0]   rk_next;
    logic [3:0][7:0]        t;
    logic [3:0]             round_cnt;
    logic [7:0]             rcon;
    logic [7:0]             rcon_next;
    logic                   accept;

    assign key_ready = (state == KEYED);
    assign in_ready  = key_ready & ~key_load & (~out_valid | out_ready);
    assign accept    = in_valid & in_ready;
    assign rcon_next = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);

    // RotWord+SubWord of the last column, then the running XOR across columns.
    always_comb begin
        t       = '0;
        rk_next = rk;
        for (int r = 0; r < 4; r++) begin
            t[r] = sbox(rk[(r + 1) % 4][3]);
        end
        t[0] = t[0] ^ rcon;
        for (int r = 0; r < 4; r++) begin
            rk_next[r][0] = rk[r][0] ^ t[r];
            for (int c = 1; c < 4; c++) begin
                rk_next[r][c] = rk[r][c] ^ rk_next[r][c-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= NOKEY;
            key0      <= '0;
            rk        <= '0;
            round_cnt <= '0;
            rcon      <= 8'h01;
        end else if (key_load) begin
            state     <= KEYED;
            key0      <= key_in;
            rk        <= key_in;
            round_cnt <= '0;
            rcon      <= 8'h01;
        end else if (accept) begin
            if (round_cnt == LAST_ROUND) begin
                rk        <= key0;
                round_cnt <= '0;
                rcon      <= 8'h01;
            end else begin
                rk        <= rk_next;
                round_cnt <= round_cnt + 4'd1;
                rcon      <= rcon_next;
            end
        end
    end

    // The output register is independent of key_load so a pending result still drains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out       <= '0;
            out_round <= '0;
            out_last  <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out       <= in ^ rk;
            out_round <= round_cnt;
            out_last  <= (round_cnt == LAST_ROUND);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_add_round_key_stage.sv
// Self-checking bench for add_round_key_stage against a FIPS-197 style key schedule model.
// The S-box is derived arithmetically (GF(2^8) inverse plus affine map).
module tb_add_round_key_stage;

    logic                 clk;
    logic                 rst_n;
    logic                 key_load;
    logic [3:0][3:0][7:0] key_in;
    logic                 key_ready;
    logic                 in_valid;
    logic                 in_ready;
    logic [3:0][3:0][7:0] in;
    logic                 out_valid;
    logic                 out_ready;
    logic [3:0][3:0][7:0] out;
    logic [3:0]           out_round;
    logic                 out_last;

    int checks = 0;
    int errors = 0;

    logic [7:0]   sb [256];
    logic [127:0] m_rk [11];
    logic         m_keyed;
    logic         m_valid;
    int           m_round;
    int           m_oround;
    logic [127:0] m_out;

    localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;

    add_round_key_stage #(.NR(10)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_load  (key_load),
        .key_in    (key_in),
        .key_ready (key_ready),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in        (in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .out_round (out_round),
        .out_last  (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hex block order is column-major: byte k is row k%4 of column k/4.
    function automatic logic [3:0][3:0][7:0] to_state(input logic [127:0] h);
        logic [3:0][3:0][7:0] s;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                s[r][c] = h[127 - 8 * (4 * c + r) -: 8];
        return s;
    endfunction

    function automatic logic [127:0] to_hex(input logic [3:0][3:0][7:0] s);
        logic [127:0] h;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                h[127 - 8 * (4 * c + r) -: 8] = s[r][c];
        return h;
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
        return (b << k) | (b >> (8 - k));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic expand_key(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] tmp;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32 * i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]};
                tmp = tmp ^ {rc, 24'h0};
                rc  = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int r = 0; r < 11; r++) m_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One clock cycle: drive, check in_ready, clock, advance model, check outputs.
    task automatic step(input logic kl, input logic [127:0] kh, input logic iv,
                        input logic [127:0] ih, input logic ordy);
        logic exp_ready;
        logic acc;
        key_load  = kl;
        key_in    = to_state(kh);
        in_valid  = iv;
        in        = to_state(ih);
        out_ready = ordy;
        #1;
        exp_ready = m_keyed & ~kl & (~m_valid | ordy);
        check("in_ready", 128'(in_ready), 128'(exp_ready));
        acc = iv & exp_ready;
        @(posedge clk);
        #1;
        if (acc) begin
            m_out    = ih ^ m_rk[m_round];
            m_oround = m_round;
            m_valid  = 1'b1;
            m_round  = (m_round == 10) ? 0 : m_round + 1;
        end else if (ordy) begin
            m_valid = 1'b0;
        end
        if (kl) begin
            m_keyed = 1'b1;
            expand_key(kh);
            m_round = 0;
        end
        check("out_valid", 128'(out_valid), 128'(m_valid));
        check("key_ready", 128'(key_ready), 128'(m_keyed));
        if (m_valid) begin
            check("out", to_hex(out), m_out);
            check("out_round", 128'(out_round), 128'(m_oround));
            check("out_last", 128'(out_last), 128'(m_oround == 10));
        end
    endtask

    initial begin
        logic [127:0] x;
        build_sbox();
        m_keyed   = 1'b0;
        m_valid   = 1'b0;
        m_round   = 0;
        m_oround  = 0;
        m_out     = '0;
        rst_n     = 1'b0;
        key_load  = 1'b0;
        key_in    = '0;
        in_valid  = 1'b0;
        in        = '0;
        out_ready = 1'b0;
        #3;
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_key_ready", 128'(key_ready), 128'(0));
        check("rst_out", to_hex(out), 128'(0));
        check("rst_out_round", 128'(out_round), 128'(0));
        check("rst_out_last", 128'(out_last), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Beats offered before any key are ignored.
        step(1'b0, '0, 1'b1, rnd128(), 1'b1);
        step(1'b0, '0, 1'b1, rnd128(), 1'b1);

        step(1'b1, K1, 1'b0, '0, 1'b1);

        // Twelve back-to-back zero beats cover rounds 0..10 and the wrap to round 0.
        for (int i = 0; i < 12; i++) begin
            step(1'b0, '0, 1'b1, '0, 1'b1);
            if (i == 0) check("kat_r0", to_hex(out), K1);
            if (i == 1) check("kat_r1", to_hex(out), 128'ha0fafe1788542cb123a339392a6c7605);
            if (i == 10) begin
                check("kat_r10", to_hex(out), 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
                check("kat_r10_last", 128'(out_last), 128'(1));
            end
            if (i == 11) begin
                check("kat_wrap", to_hex(out), K1);
                check("kat_wrap_round", 128'(out_round), 128'(0));
            end
        end

        // Backpressure: hold round 1 for three cycles, then release with a beat waiting.
        step(1'b0, '0, 1'b1, '0, 1'b1);
        x = rnd128();
        for (int i = 0; i < 3; i++) begin
            step(1'b0, '0, 1'b1, x, 1'b0);
            check("bp_round", 128'(out_round), 128'(1));
        end
        step(1'b0, '0, 1'b1, x, 1'b1);
        check("bp_release_round", 128'(out_round), 128'(2));

        for (int i = 0; i < 40; i++)
            step(1'b0, '0, 1'($urandom_range(0, 3) != 0), rnd128(), 1'($urandom_range(0, 2) != 0));

        // Abort at round_cnt 4 with a result pending.
        for (int i = 0; i < 12; i++) begin
            step(1'b0, '0, 1'b1, rnd128(), 1'b1);
            if (m_round == 4) break;
        end
        check("abort_setup_round", 128'(m_round), 128'(4));
        x = rnd128();
        step(1'b1, K2, 1'b1, x, 1'b0);
        check("abort_pending_round", 128'(out_round), 128'(3));
        step(1'b0, '0, 1'b1, x, 1'b0);
        step(1'b0, '0, 1'b1, x, 1'b1);
        check("abort_r0", to_hex(out), x ^ K2);
        check("abort_r0_round", 128'(out_round), 128'(0));
        step(1'b0, '0, 1'b1, '0, 1'b1);
        check("abort_r1", to_hex(out), 128'hd6aa74fdd2af72fadaa678f1d6ab76fe);

        // Reset mid-block, then beats without a key.
        step(1'b0, '0, 1'b1, rnd128(), 1'b0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 128'(out_valid), 128'(0));
        check("mid_rst_key_ready", 128'(key_ready), 128'(0));
        check("mid_rst_out", to_hex(out), 128'(0));
        check("mid_rst_out_round", 128'(out_round), 128'(0));
        check("mid_rst_out_last", 128'(out_last), 128'(0));
        m_keyed = 1'b0;
        m_valid = 1'b0;
        m_round = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(1'b0, '0, 1'b1, rnd128(), 1'b1);
        step(1'b0, '0, 1'b1, rnd128(), 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
